// File: rtl/smi_mem_lib_write_burst_test_gen64_pkg.sv
// Shared definitions for the memory access library burst test blocks.
// The read burst checker uses the same state encodings and widths, so the
// two sides of a write-then-verify test stay in step.
package smi_mem_lib_write_burst_test_gen64_pkg;

  // Fixed datapath widths
  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 32;
  localparam int OPTS_W = 8;

  // Burst test state encodings (plain constants so older blocks can share them)
  localparam logic [1:0] STATE_IDLE       = 2'd0;
  localparam logic [1:0] STATE_SET_PARAMS = 2'd1;
  localparam logic [1:0] STATE_WRITE_DATA = 2'd2;
  localparam logic [1:0] STATE_GET_STATUS = 2'd3;

endpackage

// File: rtl/smi_mem_lib_write_burst_test_gen64.sv
// Write burst test generator: takes one test parameter set, issues a single
// write burst request, streams a 64-bit counting sequence as the burst data
// and forwards the controller's completion status back to the test harness.
module smi_mem_lib_write_burst_test_gen64
  import smi_mem_lib_write_burst_test_gen64_pkg::*;
(
  input  logic              clk,
  input  logic              srst,

  input  logic              testParamsValid,
  input  logic [ADDR_W-1:0] testParamBurstAddr,
  input  logic [LEN_W-1:0]  testParamBurstLen,
  input  logic [OPTS_W-1:0] testParamBurstOpts,
  input  logic [DATA_W-1:0] testParamDataInit,
  input  logic [DATA_W-1:0] testParamDataIncr,
  output logic              testParamsStop,

  output logic              testDoneValid,
  output logic              testDoneStatusOk,
  input  logic              testDoneStop,

  output logic              writeParamsValid,
  output logic [ADDR_W-1:0] writeParamBurstAddr,
  output logic [LEN_W-1:0]  writeParamBurstLen,
  output logic [OPTS_W-1:0] writeParamBurstOpts,
  input  logic              writeParamsStop,

  output logic              writeDataValid,
  output logic [DATA_W-1:0] writeDataValue,
  input  logic              writeDataStop,

  input  logic              writeDoneValid,
  input  logic              writeDoneStatusOk,
  output logic              writeDoneStop
);

  logic [1:0]        state;
  logic [1:0]        stateNext;

  logic [ADDR_W-1:0] addrReg;
  logic [LEN_W-1:0]  lenReg;
  logic [OPTS_W-1:0] optsReg;
  logic [DATA_W-1:0] dataVal;
  logic [DATA_W-1:0] dataIncr;
  logic [LEN_W-1:0]  wordCount;

  logic              dataXfer;
  logic              lastWord;

  assign dataXfer = (state == STATE_WRITE_DATA) && !writeDataStop;
  assign lastWord = (wordCount == LEN_W'(1));

  // Next-state selection for the single-burst test sequence
  always_comb begin
    stateNext = state;
    case (state)
      STATE_IDLE: begin
        if (testParamsValid) stateNext = STATE_SET_PARAMS;
      end
      STATE_SET_PARAMS: begin
        if (!writeParamsStop) begin
          stateNext = (lenReg != '0) ? STATE_WRITE_DATA : STATE_GET_STATUS;
        end
      end
      STATE_WRITE_DATA: begin
        if (dataXfer && lastWord) stateNext = STATE_GET_STATUS;
      end
      STATE_GET_STATUS: begin
        if (writeDoneValid && !testDoneStop) stateNext = STATE_IDLE;
      end
      default: stateNext = STATE_IDLE;
    endcase
  end

  // State register; only the control state is reset
  always_ff @(posedge clk) begin
    if (srst) state <= STATE_IDLE;
    else      state <= stateNext;
  end

  // Datapath: shadow the test inputs while idle, then step the sequence on each data transfer
  always_ff @(posedge clk) begin
    if (state == STATE_IDLE) begin
      addrReg   <= testParamBurstAddr;
      lenReg    <= testParamBurstLen;
      optsReg   <= testParamBurstOpts;
      dataVal   <= testParamDataInit;
      dataIncr  <= testParamDataIncr;
      wordCount <= testParamBurstLen;
    end else if (dataXfer) begin
      dataVal   <= dataVal + dataIncr;
      wordCount <= wordCount - LEN_W'(1);
    end
  end

  // Handshake outputs decoded from state; srst forces the idle-side values
  // immediately so nothing leaks out during the reset cycle itself
  always_comb begin
    testParamsStop   = (state != STATE_IDLE);
    writeParamsValid = (state == STATE_SET_PARAMS);
    writeDataValid   = (state == STATE_WRITE_DATA);
    testDoneValid    = 1'b0;
    writeDoneStop    = 1'b1;
    if (state == STATE_GET_STATUS) begin
      testDoneValid = writeDoneValid;
      writeDoneStop = testDoneStop;
    end
    if (srst) begin
      testParamsStop   = 1'b0;
      writeParamsValid = 1'b0;
      writeDataValid   = 1'b0;
      testDoneValid    = 1'b0;
      writeDoneStop    = 1'b1;
    end
  end

  assign testDoneStatusOk    = writeDoneStatusOk;
  assign writeParamBurstAddr = addrReg;
  assign writeParamBurstLen  = lenReg;
  assign writeParamBurstOpts = optsReg;
  assign writeDataValue      = dataVal;

endmodule

// File: tb/tb_smi_mem_lib_write_burst_test_gen64.sv
// Directed bench for the write burst test generator. The bench plays the
// write burst controller and the test harness, driving inputs at the falling
// edge and checking outputs away from the rising edge.
module tb_smi_mem_lib_write_burst_test_gen64;

  logic        clk = 1'b0;
  logic        srst;
  logic        testParamsValid;
  logic [63:0] testParamBurstAddr;
  logic [31:0] testParamBurstLen;
  logic [7:0]  testParamBurstOpts;
  logic [63:0] testParamDataInit;
  logic [63:0] testParamDataIncr;
  logic        testParamsStop;
  logic        testDoneValid;
  logic        testDoneStatusOk;
  logic        testDoneStop;
  logic        writeParamsValid;
  logic [63:0] writeParamBurstAddr;
  logic [31:0] writeParamBurstLen;
  logic [7:0]  writeParamBurstOpts;
  logic        writeParamsStop;
  logic        writeDataValid;
  logic [63:0] writeDataValue;
  logic        writeDataStop;
  logic        writeDoneValid;
  logic        writeDoneStatusOk;
  logic        writeDoneStop;

  int total = 0;
  int bad   = 0;

  smi_mem_lib_write_burst_test_gen64 dut (
    .clk                 (clk),
    .srst                (srst),
    .testParamsValid     (testParamsValid),
    .testParamBurstAddr  (testParamBurstAddr),
    .testParamBurstLen   (testParamBurstLen),
    .testParamBurstOpts  (testParamBurstOpts),
    .testParamDataInit   (testParamDataInit),
    .testParamDataIncr   (testParamDataIncr),
    .testParamsStop      (testParamsStop),
    .testDoneValid       (testDoneValid),
    .testDoneStatusOk    (testDoneStatusOk),
    .testDoneStop        (testDoneStop),
    .writeParamsValid    (writeParamsValid),
    .writeParamBurstAddr (writeParamBurstAddr),
    .writeParamBurstLen  (writeParamBurstLen),
    .writeParamBurstOpts (writeParamBurstOpts),
    .writeParamsStop     (writeParamsStop),
    .writeDataValid      (writeDataValid),
    .writeDataValue      (writeDataValue),
    .writeDataStop       (writeDataStop),
    .writeDoneValid      (writeDoneValid),
    .writeDoneStatusOk   (writeDoneStatusOk),
    .writeDoneStop       (writeDoneStop)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Offer one parameter set from IDLE; returns at the falling edge where the block sits in SET_PARAMS
  task automatic applyStimulus(input logic [63:0] addr, input logic [31:0] len, input logic [7:0] opts,
                               input logic [63:0] init, input logic [63:0] incr);
    checkOutput("idle_params_stop", testParamsStop, 0);
    testParamBurstAddr = addr;
    testParamBurstLen  = len;
    testParamBurstOpts = opts;
    testParamDataInit  = init;
    testParamDataIncr  = incr;
    testParamsValid    = 1'b1;
    @(negedge clk);
    testParamsValid    = 1'b0;
    testParamBurstAddr = '1;
    testParamBurstLen  = '1;
    testParamDataInit  = '0;
    #1;
    checkOutput("param_valid", writeParamsValid, 1);
    checkOutput("param_addr", writeParamBurstAddr, addr);
    checkOutput("param_len", 64'(writeParamBurstLen), 64'(len));
    checkOutput("param_opts", 64'(writeParamBurstOpts), 64'(opts));
    checkOutput("busy_params_stop", testParamsStop, 1);
    checkOutput("early_done_stop", writeDoneStop, 1);
  endtask

  // Consume nWords data words, optionally stalling after word stallAfter for stallCycles cycles
  task automatic runData(input int nWords, input logic [63:0] init, input logic [63:0] incr,
                         input int stallAfter, input int stallCycles);
    logic [63:0] expVal;
    int got;
    int cyc;
    int stallLeft;
    expVal = init;
    got = 0;
    cyc = 0;
    stallLeft = 0;
    while (got < nWords && cyc < 200) begin
      @(negedge clk);
      cyc++;
      writeDataStop = (stallLeft > 0);
      #1;
      checkOutput("data_valid", writeDataValid, 1);
      checkOutput("data_value", writeDataValue, expVal);
      if (!writeDataStop) begin
        got++;
        expVal = expVal + incr;
        if (got == stallAfter) stallLeft = stallCycles;
      end else begin
        stallLeft--;
      end
    end
    checkOutput("data_count", 64'(got), 64'(nWords));
    @(negedge clk);
    writeDataStop = 1'b0;
    #1;
    checkOutput("data_extra", writeDataValid, 0);
  endtask

  // Return the controller status, holding testDoneStop for stopCycles cycles first
  task automatic finishStatus(input logic ok, input int stopCycles);
    writeDoneValid    = 1'b1;
    writeDoneStatusOk = ok;
    for (int i = 0; i < stopCycles; i++) begin
      testDoneStop = 1'b1;
      #1;
      checkOutput("done_valid_held", testDoneValid, 1);
      checkOutput("done_stop_follow", writeDoneStop, 1);
      checkOutput("done_busy_stop", testParamsStop, 1);
      @(negedge clk);
    end
    testDoneStop = 1'b0;
    #1;
    checkOutput("done_valid", testDoneValid, 1);
    checkOutput("done_ok", testDoneStatusOk, ok);
    checkOutput("done_stop_low", writeDoneStop, 0);
    @(negedge clk);
    writeDoneValid    = 1'b0;
    writeDoneStatusOk = 1'b0;
    #1;
    checkOutput("back_idle", testParamsStop, 0);
    checkOutput("idle_done_valid", testDoneValid, 0);
    checkOutput("idle_done_stop", writeDoneStop, 1);
  endtask

  // Directed test sequence
  initial begin
    srst = 1'b1;
    testParamsValid = 1'b0;
    testParamBurstAddr = '0;
    testParamBurstLen = '0;
    testParamBurstOpts = '0;
    testParamDataInit = '0;
    testParamDataIncr = '0;
    testDoneStop = 1'b0;
    writeParamsStop = 1'b0;
    writeDataStop = 1'b0;
    writeDoneValid = 1'b0;
    writeDoneStatusOk = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_param_valid", writeParamsValid, 0);
    checkOutput("rst_data_valid", writeDataValid, 0);
    checkOutput("rst_done_valid", testDoneValid, 0);
    checkOutput("rst_params_stop", testParamsStop, 0);
    checkOutput("rst_done_stop", writeDoneStop, 1);
    srst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_data_valid", writeDataValid, 0);
    checkOutput("post_rst_params_stop", testParamsStop, 0);

    $display("[TB] basic burst");
    applyStimulus(64'h1000, 32'd4, 8'h5A, 64'h10, 64'h1);
    runData(4, 64'h10, 64'h1, 0, 0);
    finishStatus(1'b1, 0);

    $display("[TB] data backpressure");
    applyStimulus(64'h2000, 32'd3, 8'h01, 64'h500, 64'h100);
    runData(3, 64'h500, 64'h100, 1, 2);
    finishStatus(1'b1, 0);

    $display("[TB] wrap and failure status");
    applyStimulus(64'h3000, 32'd2, 8'hC3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2);
    runData(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 0, 0);
    finishStatus(1'b0, 0);

    $display("[TB] zero length and done backpressure");
    applyStimulus(64'h4000, 32'd0, 8'h00, 64'h77, 64'h1);
    @(negedge clk);
    #1;
    checkOutput("zero_no_data", writeDataValid, 0);
    checkOutput("zero_done_blocked", testDoneValid, 0);
    finishStatus(1'b1, 3);

    $display("[TB] reset mid-burst");
    applyStimulus(64'h5000, 32'd8, 8'h11, 64'h0, 64'h8);
    @(negedge clk);
    #1;
    checkOutput("rst_burst_w0", writeDataValue, 64'h0);
    @(negedge clk);
    #1;
    checkOutput("rst_burst_w1", writeDataValue, 64'h8);
    @(negedge clk);
    srst = 1'b1;
    #1;
    checkOutput("rst_burst_during", writeDataValid, 0);
    @(negedge clk);
    srst = 1'b0;
    #1;
    checkOutput("rst_burst_after_data", writeDataValid, 0);
    checkOutput("rst_burst_after_stop", testParamsStop, 0);

    $display("[TB] param stall");
    applyStimulus(64'h6000, 32'd1, 8'hA5, 64'h42, 64'h3);
    writeParamsStop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checkOutput("stall_param_valid", writeParamsValid, 1);
      checkOutput("stall_param_addr", writeParamBurstAddr, 64'h6000);
      checkOutput("stall_param_len", 64'(writeParamBurstLen), 64'd1);
      checkOutput("stall_param_opts", 64'(writeParamBurstOpts), 64'hA5);
      checkOutput("stall_params_stop", testParamsStop, 1);
      checkOutput("stall_no_data", writeDataValid, 0);
    end
    writeParamsStop = 1'b0;
    runData(1, 64'h42, 64'h3, 0, 0);
    finishStatus(1'b1, 0);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so a stuck handshake can never hang the run
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/smi_mem_lib_write_burst_test_gen64.md
Name: smi_mem_lib_write_burst_test_gen64

Overview:
Memory access library write burst test generator, the write-side counterpart of the read burst test checker. It accepts one set of test parameters and issues a single write burst request to the write burst controller. It then streams a 64-bit counting sequence (init, init+incr, init+2*incr, ...) as the burst data and forwards the controller's completion status. A bench pairs it with the read checker so that the same memory region is first written and then verified.

Parameters:
None. The datapath is fixed at 64 bits, burst length at 32 bits and burst options at 8 bits.

Ports:
clk  input  1  system clock; all logic is on the rising edge
srst  input  1  synchronous reset, active-high
testParamsValid  input  1  test parameter set is valid
testParamBurstAddr  input  64  burst start address
testParamBurstLen  input  32  burst length in 64-bit words
testParamBurstOpts  input  8  burst options, passed through unchanged
testParamDataInit  input  64  first data word
testParamDataIncr  input  64  per-word increment
testParamsStop  output  1  high when the block is not in idle
testDoneValid  output  1  test completion status is valid
testDoneStatusOk  output  1  test completion status
testDoneStop  input  1  downstream backpressure on the done status
writeParamsValid  output  1  write burst request is valid
writeParamBurstAddr  output  64  latched burst address
writeParamBurstLen  output  32  latched burst length
writeParamBurstOpts  output  8  latched burst options
writeParamsStop  input  1  controller backpressure on the request
writeDataValid  output  1  write data word is valid
writeDataValue  output  64  current counting sequence word
writeDataStop  input  1  controller backpressure on the data
writeDoneValid  input  1  controller completion is valid
writeDoneStatusOk  input  1  controller completion status
writeDoneStop  output  1  backpressure to the controller on completion

Behaviour:
- Handshake convention: a transfer occurs on any cycle where valid=1 and stop=0. The sender holds valid and payload stable until that cycle.
- State register: 2 bits, reset by srst. Datapath registers (addr, len, opts, dataVal, dataIncr, wordCount) are not reset.
- States:
  - IDLE (0):
    - testParamsStop=0.
    - Every cycle, load addr/len/opts, dataVal=DataInit, dataIncr=DataIncr and wordCount=BurstLen from the test inputs.
    - On testParamsValid, go to SET_PARAMS.
  - SET_PARAMS (1):
    - writeParamsValid=1; the write param outputs are driven from the latched registers.
    - On ~writeParamsStop: go to WRITE_DATA if len!=0, else go straight to GET_STATUS.
  - WRITE_DATA (2):
    - writeDataValid=1; writeDataValue=dataVal.
    - On ~writeDataStop: dataVal+=dataIncr, modulo 2^64 (wraps silently), and wordCount-=1.
    - If wordCount==1 at that transfer, go to GET_STATUS.
    - While writeDataStop=1, hold dataVal and wordCount.
  - GET_STATUS (3):
    - testDoneValid=writeDoneValid; testDoneStatusOk=writeDoneStatusOk; writeDoneStop=testDoneStop.
    - On writeDoneValid & ~testDoneStop, go to IDLE.
- Outside GET_STATUS: writeDoneStop=1 and testDoneValid=0.
- testParamsStop=1 in every state other than IDLE.
- Outside SET_PARAMS: writeParamsValid=0. Outside WRITE_DATA: writeDataValid=0.
- Reset values, during and on the cycle after srst:
  - state=IDLE.
  - writeParamsValid=0, writeDataValid=0, testDoneValid=0.
  - testParamsStop=0, writeDoneStop=1.
  - Data outputs are don't-care.
- Reset mid-burst: the block returns to IDLE on the next edge and the burst is abandoned with no further data words. The bench must also reset the controller.
- An early writeDoneValid (seen before GET_STATUS) stays blocked by writeDoneStop=1 until the block reaches GET_STATUS.
- Latency: test parameter acceptance to writeParamsValid is 1 cycle. Param handshake to the first data word is 1 cycle. Data throughput is 1 word per cycle with no stall.
- Burst lengths of 1 and 2^32-1 are both legal. The counter decrements with no underflow, because the exit is taken at wordCount==1.

Decomposition:
- Shared package: state encodings (IDLE/SET_PARAMS/WRITE_DATA/GET_STATUS), plus width constants DATA_W=64, ADDR_W=64, LEN_W=32, OPTS_W=8. The read checker shares these encodings.
- No sub-module: a single FSM with a datapath, roughly 150 lines.

Test Plan:
- Basic burst:
  - Stimulus: addr=0x1000, len=4, init=0x10, incr=1, no stalls.
  - Required: one write param transfer carrying 0x1000/4; data words 0x10, 0x11, 0x12, 0x13; writeDoneValid with ok=1 gives testDoneValid=1, ok=1; the block returns to IDLE.
- Data backpressure:
  - Stimulus: len=3, incr=0x100; writeDataStop high for 2 cycles after the first word.
  - Required: writeDataValue holds init+0x100 through the stall; exactly 3 transfers in total.
- Wrap and failure status:
  - Stimulus: init=0xFFFFFFFFFFFFFFFF, incr=2, len=2; controller returns ok=0.
  - Required: words 0xFFFF...FFFF then 0x1; testDoneStatusOk=0.
- Zero length and done backpressure:
  - Stimulus: len=0; testDoneStop high for 3 cycles.
  - Required: no data words; writeDoneStop follows testDoneStop; IDLE is reached only after testDoneStop falls.
- Reset mid-burst:
  - Stimulus: srst for 1 cycle after the 2nd of 8 words.
  - Required: the next cycle shows writeDataValid=0 and testParamsStop=0; a new test then runs cleanly.
- Param stall:
  - Stimulus: writeParamsStop high for 5 cycles.
  - Required: writeParamsValid stays at 1 with stable addr/len/opts; testParamsStop=1 throughout.
